psk_tx_controller: RTL and testbench

//  Parametrised TX sequencer for BPSK/QPSK. Sits between the push-button, the sine generator and the symbol source.

---
 rtl/psk_ctrl_pkg.sv | 6 +
 rtl/pb_debounce.sv | 32 +++
 rtl/psk_tx_controller.sv | 105 ++++++++++
 tb/tb_psk_tx_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/psk_ctrl_pkg.sv
// psk_ctrl_pkg: shared state encoding and modulation mode constants for the PSK TX sequencer
package psk_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN, STALL} state_t;
  localparam logic MODE_BPSK = 1'b0;
  localparam logic MODE_QPSK = 1'b1;
endpackage

// File: rtl/pb_debounce.sv
// pb_debounce: 2-flop synchroniser, stability counter and rising-edge pulse for a raw push-button
module pb_debounce #(
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic pb_evt
);
  localparam int CW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
  logic s0, s1, db, db_q;
  logic [CW-1:0] cnt;
  // synchronise pb, accept a new level only after it differs from db for DEBOUNCE_CYC cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      db <= 1'b0;
      db_q <= 1'b0;
      cnt <= '0;
    end else begin
      s0 <= pb;
      s1 <= s0;
      db_q <= db;
      if (s1 == db) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        db <= s1;
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  assign pb_evt = db & ~db_q;
endmodule

// File: rtl/psk_tx_controller.sv
// psk_tx_controller: BPSK/QPSK TX sequencer (start/stop, sample pacing, symbol handshake, burst, underrun); STATUS_LED_EN adds the led port
import psk_ctrl_pkg::*;
module psk_tx_controller #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int SAMPLES_PER_SYM = 16,
  parameter int BURST_LEN = 0
`ifdef STATUS_LED_EN
  , parameter int BLINK_DIV = 25000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  input  logic mode,
  input  logic sine_rdy,
  input  logic data_rdy,
  output logic data_ack,
  output logic sine_rst,
  output logic sine_clk_en,
  output logic mod_en,
  output logic mod_mode,
  output logic busy,
  output logic underrun
`ifdef STATUS_LED_EN
  , output logic led
`endif
);
  localparam int SW = $clog2(SAMPLES_PER_SYM);
  localparam int YW = BURST_LEN > 0 ? $clog2(BURST_LEN + 1) : 1;
  state_t state, nxt;
  logic [SW-1:0] samp_cnt;
  logic [YW-1:0] sym_cnt;
  logic pb_evt, boundary, burst_done;
  pb_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
    .clk(clk),
    .rst_n(rst_n),
    .pb(pb),
    .pb_evt(pb_evt)
  );
  assign boundary = samp_cnt == SW'(SAMPLES_PER_SYM - 1);
  assign burst_done = BURST_LEN != 0 && sym_cnt == YW'(BURST_LEN);
  assign sine_rst = state == IDLE;
  assign sine_clk_en = state == RUN;
  assign mod_en = state == RUN;
  assign busy = state != IDLE;
  // next state and symbol pop; a button event aborts and suppresses any pop that cycle
  always_comb begin
    nxt = state;
    data_ack = 1'b0;
    case (state)
      IDLE: nxt = pb_evt ? ARM : IDLE;
      ARM: begin
        data_ack = !pb_evt && sine_rdy && data_rdy;
        nxt = pb_evt ? IDLE : data_ack ? RUN : ARM;
      end
      RUN: begin
        data_ack = !pb_evt && boundary && !burst_done && data_rdy;
        nxt = pb_evt ? IDLE : !boundary ? RUN : burst_done ? IDLE : data_rdy ? RUN : STALL;
      end
      STALL: begin
        data_ack = !pb_evt && data_rdy;
        nxt = pb_evt ? IDLE : data_rdy ? RUN : STALL;
      end
      default: nxt = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // sample/symbol counters, sticky underrun and mode latch; all restart on a start event
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      samp_cnt <= '0;
      sym_cnt <= '0;
      underrun <= 1'b0;
      mod_mode <= MODE_BPSK;
    end else if (state == IDLE && pb_evt) begin
      samp_cnt <= '0;
      sym_cnt <= '0;
      underrun <= 1'b0;
      mod_mode <= mode;
    end else begin
      if (state == RUN) samp_cnt <= boundary ? '0 : samp_cnt + SW'(1);
      else if (state == STALL && data_ack) samp_cnt <= '0;
      if (data_ack && sym_cnt != '1) sym_cnt <= sym_cnt + YW'(1);
      if (state == RUN && nxt == STALL) underrun <= 1'b1;
    end
`ifdef STATUS_LED_EN
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_cnt;
  // led follows activity; blinks while stalled, blink phase restarts on each stall entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      led <= 1'b0;
      blink_cnt <= '0;
    end else if (nxt != STALL || state != STALL) begin
      led <= nxt != IDLE;
      blink_cnt <= '0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      led <= ~led;
      blink_cnt <= '0;
    end else blink_cnt <= blink_cnt + BW'(1);
`endif
endmodule

// File: tb/tb_psk_tx_controller.sv
// tb_psk_tx_controller: directed bench for psk_tx_controller; burst DUT (BURST_LEN=3) and continuous DUT (BURST_LEN=0)
module tb_psk_tx_controller;
  logic clk, rst_n, pb_b, pb_c, mode, sine_rdy, data_rdy;
  logic ack_b, srst_b, en_b, men_b, mm_b, busy_b, ur_b;
  logic ack_c, srst_c, en_c, men_c, mm_c, busy_c, ur_c;
`ifdef STATUS_LED_EN
  logic led_b, led_c;
`endif
  int errors = 0;
  int checks = 0;

  psk_tx_controller #(.DEBOUNCE_CYC(4), .SAMPLES_PER_SYM(4), .BURST_LEN(3)
`ifdef STATUS_LED_EN
    , .BLINK_DIV(8)
`endif
  ) u_b (
    .clk(clk), .rst_n(rst_n), .pb(pb_b), .mode(mode), .sine_rdy(sine_rdy), .data_rdy(data_rdy),
    .data_ack(ack_b), .sine_rst(srst_b), .sine_clk_en(en_b), .mod_en(men_b), .mod_mode(mm_b),
    .busy(busy_b), .underrun(ur_b)
`ifdef STATUS_LED_EN
    , .led(led_b)
`endif
  );

  psk_tx_controller #(.DEBOUNCE_CYC(4), .SAMPLES_PER_SYM(4), .BURST_LEN(0)
`ifdef STATUS_LED_EN
    , .BLINK_DIV(8)
`endif
  ) u_c (
    .clk(clk), .rst_n(rst_n), .pb(pb_c), .mode(mode), .sine_rdy(sine_rdy), .data_rdy(data_rdy),
    .data_ack(ack_c), .sine_rst(srst_c), .sine_clk_en(en_c), .mod_en(men_c), .mod_mode(mm_c),
    .busy(busy_c), .underrun(ur_c)
`ifdef STATUS_LED_EN
    , .led(led_c)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic dr;
    logic ack;
    logic en;
    logic busy;
    logic rst;
  } vec_t;
  vec_t tbl[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic press_c();
    pb_c = 1'b1;
    for (int i = 0; i < 20 && busy_c !== 1'b1; i++) step();
    chk("press_c_busy", busy_c, 1'b1);
    pb_c = 1'b0;
  endtask

  initial begin
    int nack, nen;
    // burst timeline from the ARM cycle: pops at 0,4,8; 12 enabled samples; IDLE at 13
    for (int c = 0; c < 14; c++) begin
      tbl[c].dr = 1'b1;
      tbl[c].ack = c == 0 || c == 4 || c == 8;
      tbl[c].en = c >= 1 && c <= 12;
      tbl[c].busy = c <= 12;
      tbl[c].rst = c == 13;
    end
    clk = 0; rst_n = 0; pb_b = 0; pb_c = 0; mode = 0; sine_rdy = 0; data_rdy = 0;
    repeat (3) step();
    chk("rst_sine_rst", srst_c, 1'b1);
    chk("rst_clk_en", en_c, 1'b0);
    chk("rst_mod_en", men_c, 1'b0);
    chk("rst_busy", busy_c, 1'b0);
    chk("rst_underrun", ur_c, 1'b0);
    chk("rst_mod_mode", mm_c, 1'b0);
    chk("rst_data_ack", ack_c, 1'b0);
`ifdef STATUS_LED_EN
    chk("rst_led", led_c, 1'b0);
`endif
    rst_n = 1;
    step();
    pb_c = 1; pb_b = 1;
    step(); step();
    pb_c = 0; pb_b = 0;
    repeat (10) step();
    chk("glitch_busy_c", busy_c, 1'b0);
    chk("glitch_busy_b", busy_b, 1'b0);
    chk("glitch_sine_rst", srst_c, 1'b1);

    mode = 1; sine_rdy = 1; data_rdy = 1; pb_b = 1;
    for (int i = 0; i < 20 && busy_b !== 1'b1; i++) step();
    chk("burst_start", busy_b, 1'b1);
    chk("burst_mod_mode", mm_b, 1'b1);
    nack = 0; nen = 0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) step();
      data_rdy = tbl[c].dr;
      #1;
      chk($sformatf("burst_ack[%0d]", c), ack_b, tbl[c].ack);
      chk($sformatf("burst_en[%0d]", c), en_b, tbl[c].en);
      chk($sformatf("burst_busy[%0d]", c), busy_b, tbl[c].busy);
      chk($sformatf("burst_rst[%0d]", c), srst_b, tbl[c].rst);
      nack += int'(ack_b);
      nen += int'(en_b);
    end
    chk("burst_ack_total", nack == 3, 1'b1);
    chk("burst_en_total", nen == 12, 1'b1);
    pb_b = 0;
    repeat (10) step();
    chk("release_ignored", busy_b, 1'b0);

    mode = 0; data_rdy = 1;
    press_c();
    chk("arm_ack", ack_c, 1'b1);
    chk("cont_mod_mode", mm_c, 1'b0);
    repeat (4) step();
    chk("bnd1_ack", ack_c, 1'b1);
    step();
    data_rdy = 0;
    repeat (3) step();
    chk("bnd2_noack", ack_c, 1'b0);
    step();
    chk("stall_clk_en", en_c, 1'b0);
    chk("stall_mod_en", men_c, 1'b0);
    chk("stall_sine_rst", srst_c, 1'b0);
    chk("stall_busy", busy_c, 1'b1);
    chk("stall_underrun", ur_c, 1'b1);
`ifdef STATUS_LED_EN
    chk("led_stall_entry", led_c, 1'b1);
    repeat (8) step();
    chk("led_toggle1", led_c, 1'b0);
    repeat (8) step();
    chk("led_toggle2", led_c, 1'b1);
`else
    repeat (4) step();
    chk("stall_hold", en_c, 1'b0);
`endif
    data_rdy = 1;
    #1;
    chk("stall_ack", ack_c, 1'b1);
    step();
    chk("resume_clk_en", en_c, 1'b1);
    chk("resume_mod_en", men_c, 1'b1);
    chk("underrun_sticky", ur_c, 1'b1);

    pb_c = 1;
    repeat (3) step();
    chk("run_bnd_ack", ack_c, 1'b1);
    repeat (2) step();
    chk("abort_pre_busy", busy_c, 1'b1);
    step();
    chk("abort_noack", ack_c, 1'b0);
    step();
    chk("abort_busy", busy_c, 1'b0);
    chk("abort_sine_rst", srst_c, 1'b1);
    chk("abort_clk_en", en_c, 1'b0);
`ifdef STATUS_LED_EN
    chk("abort_led", led_c, 1'b0);
`endif
    pb_c = 0;
    repeat (8) step();

    sine_rdy = 0; mode = 1; data_rdy = 1;
    press_c();
    chk("restart_underrun_clr", ur_c, 1'b0);
    chk("restart_mod_mode", mm_c, 1'b1);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("arm_wait_ack[%0d]", i), ack_c, 1'b0);
      chk($sformatf("arm_wait_en[%0d]", i), en_c, 1'b0);
      chk($sformatf("arm_wait_rst[%0d]", i), srst_c, 1'b0);
      step();
    end
    sine_rdy = 1;
    #1;
    chk("arm_rdy_ack", ack_c, 1'b1);
    step();
    chk("arm_rdy_run", en_c, 1'b1);
    chk("arm_rdy_busy", busy_c, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
